mem_bus_ctrl: RTL
=================

// Module: mem_bus_ctrl
// PURPOSE
//  - Sequencer directly downstream of the memory-access stage. Consumes its level-held RAM request
//    (ram_addr/ram_r_ena/ram_w_ena/ram_w_mask/ram_w_data) and runs one valid/ready bus transaction.
//  - Stalls the pipeline until the bus responds.
//  - Returns the raw 64-bit doubleword on ram_r_data; the memory-access stage does byte/half/word extraction.
// PARAMETERS
//  - ADDR_W       64   request address width
//  - DATA_W       64   data width; strobe width is DATA_W/8
//  - TIMEOUT_CYC  256  cycles in WAIT_RSP before abort (used only with MEM_BUS_TIMEOUT_EN)
// PORTS
//  - clk            in   1         clock, rising edge
//  - rst            in   1         reset, asynchronous, active-high
//  - ram_addr       in   ADDR_W    byte address from memory-access stage
//  - ram_r_ena      in   1         load request, held until stall_req drops
//  - ram_w_ena      in   1         store request, held until stall_req drops
//  - ram_w_mask     in   DATA_W    per-bit write mask, byte-granular
//  - ram_w_data     in   DATA_W    lane-aligned store data
//  - ram_r_data     out  DATA_W    raw doubleword of last completed load
//  - stall_req      out  1         freeze all stages up to and including memory-access
//  - bus_req_valid  out  1         request valid
//  - bus_req_ready  in   1         request accepted
//  - bus_req_we     out  1         1 = write, 0 = read
//  - bus_req_addr   out  ADDR_W    {ram_addr[ADDR_W-1:3], 3'b0}
//  - bus_req_wdata  out  DATA_W    store data
//  - bus_req_wstrb  out  DATA_W/8  wstrb[i] = &ram_w_mask[8i+7:8i]; all-zero on reads
//  - bus_rsp_valid  in   1         read data / write ack valid, one-cycle pulse
//  - bus_rsp_data   in   DATA_W    read data; ignored for writes
//  - bus_err        out  1         timeout sticky flag (MEM_BUS_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE; bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb=0;
//    ram_r_data=0; bus_err=0. stall_req=0 while rst is high.
//  - FSM IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE.
//    - IDLE: if (ram_r_ena|ram_w_ena): latch addr/we/wdata/wstrb into bus_req_* regs, go to REQ.
//      If both enables are high, the write wins (we=1).
//    - REQ: bus_req_valid=1. Request fields stay stable until bus_req_valid & bus_req_ready,
//      then go to WAIT_RSP and drop valid at that edge.
//    - WAIT_RSP: on bus_rsp_valid, go to DONE. For a read, ram_r_data <= bus_rsp_data.
//      For a write, ram_r_data is unchanged. bus_rsp_valid is not sampled in REQ.
//    - DONE: one cycle; stall_req=0 so the pipeline advances; the held request is not re-sampled.
//      Always returns to IDLE.
//  - stall_req (combinational) = (IDLE & (ram_r_ena|ram_w_ena)) | REQ | WAIT_RSP.
//  - Latency, zero-wait bus: request seen in cycle 0; valid & ready in cycle 1; rsp in cycle 2;
//    DONE in cycle 3. Minimum 4 cycles per access, stall high in cycles 0-2.
//  - ram_r_data holds its last value outside DONE. It is meaningful only in the DONE cycle of a read.
//  - Back-to-back requests: a new request is taken only from IDLE, so there is one idle cycle after DONE.
//  - bus_rsp_valid seen in IDLE, REQ or DONE is ignored (this covers a stale response after reset).
//  - Async reset mid-transaction: drop bus_req_valid immediately; any outstanding response is then
//    ignored per the rule above.
//  - No misalignment check: only addr[2:0] lanes in the mask matter; bus_req_addr is always 8-byte aligned.
// CONFIGURATION
//  - MEM_BUS_TIMEOUT_EN defined:
//    - A counter clears on entering WAIT_RSP and increments each WAIT_RSP cycle.
//    - When the counter reaches TIMEOUT_CYC-1 without a response: go to DONE, set ram_r_data=0 for a
//      read, and set bus_err=1 (sticky until rst).
//    - A response arriving in that same cycle wins: normal completion, no error.
//  - MEM_BUS_TIMEOUT_EN undefined: no counter; WAIT_RSP waits forever; bus_err tied to 0.
// TESTING
//  - Read, zero-wait: ram_addr=0x8000_0013, r_ena; ready=1; rsp data 0x1122_3344_5566_7788 next cycle
//    -> bus_req_addr=0x8000_0010, wstrb=0x00, stall 3 cycles,
//       ram_r_data=0x1122334455667788 in DONE.
//  - Write: ram_addr=0x8000_0006, mask=0xFFFF_0000_0000_0000, data=0xBEEF<<48, ready delayed 3 cycles
//    -> valid held 4 cycles, fields stable, we=1, wstrb=0xC0, addr=0x8000_0000.
//  - Read then write back-to-back -> exactly one transaction each, one idle cycle between them,
//    no duplicate issue in DONE.
//  - Reset asserted in WAIT_RSP, rsp_valid arrives 2 cycles after release
//    -> valid=0 and stall=0 during reset; response ignored; ram_r_data stays 0.
//  - Both r_ena and w_ena high -> single write transaction, we=1.
//  - MEM_BUS_TIMEOUT_EN, TIMEOUT_CYC=8, no rsp -> DONE after 8 WAIT_RSP cycles, ram_r_data=0,
//    bus_err=1 and held; without the macro, stall held >1000 cycles and bus_err=0.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns the memory-access stage's level-held RAM request into a
// single valid/ready bus transaction and stalls the pipeline until it completes.
//
// Optional feature macro: MEM_BUS_TIMEOUT_EN
//   defined   - WAIT_RSP aborts after TIMEOUT_CYC cycles without a response;
//               bus_err is set and stays set until rst.
//   undefined - WAIT_RSP waits indefinitely; bus_err is tied to 0.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   ram_addr/ram_r_ena/ram_w_ena/ram_w_mask/ram_w_data
//                               request from the memory-access stage
//   ram_r_data                  raw doubleword of the last completed load
//   stall_req                   freeze the pipeline up to the memory-access stage
//   bus_req_valid/ready/we/addr/wdata/wstrb
//                               bus request channel
//   bus_rsp_valid/bus_rsp_data  bus response channel
//   bus_err                     sticky timeout flag
module mem_bus_ctrl #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ram_addr,
  input  logic                ram_r_ena,
  input  logic                ram_w_ena,
  input  logic [DATA_W-1:0]   ram_w_mask,
  input  logic [DATA_W-1:0]   ram_w_data,
  output logic [DATA_W-1:0]   ram_r_data,
  output logic                stall_req,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_req_we,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic [DATA_W-1:0]   bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_wstrb,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rsp_data,
  output logic                bus_err
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state;
  logic              req_any;
  logic [STRB_W-1:0] strb_c;

  assign req_any = ram_r_ena | ram_w_ena;

  // A byte lane is written only if its whole mask byte is set.
  always_comb begin
    strb_c = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      strb_c[i] = &ram_w_mask[8*i +: 8];
    end
  end

  // Stall asserts in the same cycle the request appears; DONE releases it.
  assign stall_req = !rst && (((state == IDLE) && req_any) ||
                              (state == REQ) || (state == WAIT_RSP));

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             unused_ok;

  assign unused_ok = ^ram_addr[2:0];
`else
  logic unused_ok;

  // Low address bits select lanes via the mask only; TIMEOUT_CYC has no use here.
  assign unused_ok = ^{ram_addr[2:0], TIMEOUT_CYC[0]};
  assign bus_err   = 1'b0;
`endif

  // Transaction sequencer with registered bus-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
      ram_r_data    <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      tmo_cnt       <= '0;
      bus_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state         <= REQ;
            bus_req_valid <= 1'b1;
            // Write wins when both enables are high.
            bus_req_we    <= ram_w_ena;
            bus_req_addr  <= {ram_addr[ADDR_W-1:3], 3'b000};
            bus_req_wdata <= ram_w_data;
            bus_req_wstrb <= ram_w_ena ? strb_c : '0;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            state         <= WAIT_RSP;
            bus_req_valid <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        WAIT_RSP: begin
          // A response in the final timeout cycle still completes normally.
          if (bus_rsp_valid) begin
            state <= DONE;
            if (!bus_req_we) begin
              ram_r_data <= bus_rsp_data;
            end
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state   <= DONE;
            bus_err <= 1'b1;
            if (!bus_req_we) begin
              ram_r_data <= '0;
            end
          end
          tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
        end
        DONE: begin
          // The request is still held here; it must not be re-sampled.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
